// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow sequencer for the pong datapath.
// Gates ball/paddle movement, holds the ball at centre while serving,
// tracks both players' scores and declares the winner.
// Optional build macro PONG_PAUSE_EN adds a level-sensitive pause input
// and a paused status output.

module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 32,
    parameter int POINT_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        miss_l,
    input  logic        miss_r,
    output logic        ball_en,
    output logic        ball_rst,
    output logic        serve_dir,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic [15:0] score,
    output logic        game_over,
    output logic        winner,
    output logic [2:0]  state_dbg
`ifdef PONG_PAUSE_EN
    ,
    input  logic        pause,
    output logic        paused
`endif
);

    // The delay counter must hold the larger of the two hold times.
    localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CW        = $clog2(MAX_TICKS) + 1;

    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_TICKS);
    localparam logic [CW-1:0] POINT_LOAD = CW'(POINT_TICKS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          start_q;
    logic          start_pulse;
    logic          pause_hold;
    logic [3:0]    p1_inc;
    logic [3:0]    p2_inc;

    assign start_pulse = start & ~start_q;
    assign p1_inc      = score_p1 + 4'd1;
    assign p2_inc      = score_p2 + 4'd1;

`ifdef PONG_PAUSE_EN
    assign pause_hold = pause && ((state == SERVE) || (state == PLAY) || (state == POINT));
`else
    assign pause_hold = 1'b0;
`endif

    assign score     = {4'h0, score_p1, 4'h0, score_p2};
    assign state_dbg = state;

    // Game FSM: state, counter, scores and all registered outputs move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            start_q   <= 1'b0;
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            ball_en   <= 1'b0;
            ball_rst  <= 1'b1;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
`ifdef PONG_PAUSE_EN
            paused    <= 1'b0;
`endif
        end else begin
            start_q <= start;
            if (pause_hold) begin
                ball_en <= 1'b0;
`ifdef PONG_PAUSE_EN
                paused  <= 1'b1;
`endif
            end else begin
`ifdef PONG_PAUSE_EN
                paused <= 1'b0;
`endif
                case (state)
                    IDLE: begin
                        ball_en  <= 1'b0;
                        ball_rst <= 1'b1;
                        if (start_pulse) begin
                            score_p1 <= 4'd0;
                            score_p2 <= 4'd0;
                            cnt      <= SERVE_LOAD;
                            state    <= SERVE;
                        end
                    end

                    SERVE: begin
                        if (tick) begin
                            if (cnt == CNT_ONE) begin
                                state    <= PLAY;
                                ball_en  <= 1'b1;
                                ball_rst <= 1'b0;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end

                    PLAY: begin
                        ball_en <= 1'b1;
                        if (miss_l && miss_r) begin
                            cnt      <= SERVE_LOAD;
                            state    <= SERVE;
                            ball_en  <= 1'b0;
                            ball_rst <= 1'b1;
                        end else if (miss_r) begin
                            score_p1  <= p1_inc;
                            serve_dir <= 1'b1;
                            ball_en   <= 1'b0;
                            if (p1_inc == WIN) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= 1'b0;
                                ball_rst  <= 1'b1;
                            end else begin
                                cnt      <= POINT_LOAD;
                                state    <= POINT;
                                ball_rst <= 1'b0;
                            end
                        end else if (miss_l) begin
                            score_p2  <= p2_inc;
                            serve_dir <= 1'b0;
                            ball_en   <= 1'b0;
                            if (p2_inc == WIN) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= 1'b1;
                                ball_rst  <= 1'b1;
                            end else begin
                                cnt      <= POINT_LOAD;
                                state    <= POINT;
                                ball_rst <= 1'b0;
                            end
                        end
                    end

                    POINT: begin
                        if (tick) begin
                            if (cnt == CNT_ONE) begin
                                cnt      <= SERVE_LOAD;
                                state    <= SERVE;
                                ball_rst <= 1'b1;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end

                    OVER: begin
                        ball_en  <= 1'b0;
                        ball_rst <= 1'b1;
                        if (start_pulse) begin
                            score_p1  <= 4'd0;
                            score_p2  <= 4'd0;
                            game_over <= 1'b0;
                            cnt       <= SERVE_LOAD;
                            state     <= SERVE;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        ball_en   <= 1'b0;
                        ball_rst  <= 1'b1;
                        game_over <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl.
// Uses short hold times (SERVE 4, POINT 2) and a 3-point game.

module tb_pong_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        start;
    logic        miss_l;
    logic        miss_r;
    logic        ball_en;
    logic        ball_rst;
    logic        serve_dir;
    logic [3:0]  score_p1;
    logic [3:0]  score_p2;
    logic [15:0] score;
    logic        game_over;
    logic        winner;
    logic [2:0]  state_dbg;
`ifdef PONG_PAUSE_EN
    logic        pause;
    logic        paused;
`endif

    int checks = 0;
    int fails  = 0;

    pong_game_ctrl #(
        .WIN_SCORE  (3),
        .SERVE_TICKS(4),
        .POINT_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .miss_l   (miss_l),
        .miss_r   (miss_r),
        .ball_en  (ball_en),
        .ball_rst (ball_rst),
        .serve_dir(serve_dir),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .score    (score),
        .game_over(game_over),
        .winner   (winner),
        .state_dbg(state_dbg)
`ifdef PONG_PAUSE_EN
        ,
        .pause    (pause),
        .paused   (paused)
`endif
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Advance n clock edges, settling 1 unit after each edge.
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick pulse followed by idle cycles, mimicking the slow move rate.
    task automatic apply_stimulus(input int n_ticks);
        for (int i = 0; i < n_ticks; i++) begin
            tick = 1'b1;
            cycle(1);
            tick = 1'b0;
            cycle(4);
        end
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        cycle(1);
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        tick   = 1'b0;
        start  = 1'b0;
        miss_l = 1'b0;
        miss_r = 1'b0;
`ifdef PONG_PAUSE_EN
        pause  = 1'b0;
`endif
        cycle(2);
        check_output("rst_state", 16'(state_dbg), 16'd0);
        check_output("rst_ball_en", 16'(ball_en), 16'd0);
        check_output("rst_ball_rst", 16'(ball_rst), 16'd1);
        check_output("rst_score", score, 16'h0000);
        check_output("rst_game_over", 16'(game_over), 16'd0);
        check_output("rst_serve_dir", 16'(serve_dir), 16'd0);
        rst = 1'b0;
        cycle(1);
        check_output("idle_hold", 16'(state_dbg), 16'd0);

        // Start and serve countdown
        start = 1'b1;
        cycle(1);
        check_output("start_serve", 16'(state_dbg), 16'd1);
        for (int i = 1; i <= 3; i++) begin
            tick = 1'b1;
            cycle(1);
            tick = 1'b0;
            check_output("serve_state", 16'(state_dbg), 16'd1);
            check_output("serve_ball_rst", 16'(ball_rst), 16'd1);
            check_output("serve_ball_en", 16'(ball_en), 16'd0);
            cycle(4);
        end
        tick = 1'b1;
        cycle(1);
        tick = 1'b0;
        check_output("play_state", 16'(state_dbg), 16'd2);
        check_output("play_ball_en", 16'(ball_en), 16'd1);
        check_output("play_ball_rst", 16'(ball_rst), 16'd0);
        start = 1'b0;
        cycle(2);
        check_output("play_tick_ignored", 16'(state_dbg), 16'd2);

        // P1 scores, POINT freeze, then serve again
        pulse_miss(1'b0, 1'b1);
        check_output("p1_score", 16'(score_p1), 16'd1);
        check_output("p1_word", score, 16'h0100);
        check_output("p1_dir", 16'(serve_dir), 16'd1);
        check_output("point_state", 16'(state_dbg), 16'd3);
        check_output("point_ball_en", 16'(ball_en), 16'd0);
        check_output("point_ball_rst", 16'(ball_rst), 16'd0);
        apply_stimulus(1);
        check_output("point_mid", 16'(state_dbg), 16'd3);
        apply_stimulus(1);
        check_output("point_to_serve", 16'(state_dbg), 16'd1);
        check_output("point_serve_rst", 16'(ball_rst), 16'd1);
        apply_stimulus(4);
        check_output("replay", 16'(state_dbg), 16'd2);

        // P2 scores to 1-1, then simultaneous misses
        pulse_miss(1'b1, 1'b0);
        check_output("p2_word", score, 16'h0101);
        check_output("p2_dir", 16'(serve_dir), 16'd0);
        apply_stimulus(6);
        check_output("replay2", 16'(state_dbg), 16'd2);
        pulse_miss(1'b1, 1'b1);
        check_output("both_word", score, 16'h0101);
        check_output("both_dir", 16'(serve_dir), 16'd0);
        check_output("both_state", 16'(state_dbg), 16'd1);
        check_output("both_ball_rst", 16'(ball_rst), 16'd1);
        apply_stimulus(4);
        pulse_miss(1'b0, 1'b1);
        check_output("two_one", score, 16'h0201);
        apply_stimulus(6);
        check_output("two_one_play", 16'(ball_en), 16'd1);

        // Synchronous reset mid-game
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        check_output("mid_rst_state", 16'(state_dbg), 16'd0);
        check_output("mid_rst_score", score, 16'h0000);
        check_output("mid_rst_ball_en", 16'(ball_en), 16'd0);
        check_output("mid_rst_ball_rst", 16'(ball_rst), 16'd1);
        check_output("mid_rst_over", 16'(game_over), 16'd0);

        // P2 wins 3-0 with start held high throughout
        start = 1'b1;
        cycle(1);
        check_output("game2_serve", 16'(state_dbg), 16'd1);
        apply_stimulus(4);
        pulse_miss(1'b1, 1'b0);
        apply_stimulus(6);
        pulse_miss(1'b1, 1'b0);
        check_output("p2_two", score, 16'h0002);
        apply_stimulus(6);
        pulse_miss(1'b1, 1'b0);
        check_output("win_word", score, 16'h0003);
        check_output("win_over", 16'(game_over), 16'd1);
        check_output("win_winner", 16'(winner), 16'd1);
        check_output("win_state", 16'(state_dbg), 16'd4);
        check_output("win_ball_en", 16'(ball_en), 16'd0);
        check_output("win_ball_rst", 16'(ball_rst), 16'd1);
        pulse_miss(1'b1, 1'b0);
        apply_stimulus(1);
        check_output("over_miss_ignored", score, 16'h0003);
        check_output("held_start_no_retrig", 16'(state_dbg), 16'd4);
        start = 1'b0;
        cycle(1);
        start = 1'b1;
        cycle(1);
        check_output("restart_state", 16'(state_dbg), 16'd1);
        check_output("restart_score", score, 16'h0000);
        check_output("restart_over", 16'(game_over), 16'd0);
        start = 1'b0;

`ifdef PONG_PAUSE_EN
        // Pause freezes the serve countdown and blocks misses
        apply_stimulus(1);
        pause = 1'b1;
        cycle(1);
        check_output("paused_flag", 16'(paused), 16'd1);
        apply_stimulus(10);
        check_output("paused_hold", 16'(state_dbg), 16'd1);
        pause = 1'b0;
        cycle(1);
        check_output("unpaused_flag", 16'(paused), 16'd0);
        apply_stimulus(2);
        check_output("resume_serve", 16'(state_dbg), 16'd1);
        apply_stimulus(1);
        check_output("resume_play", 16'(state_dbg), 16'd2);
        pause = 1'b1;
        cycle(1);
        check_output("pause_ball_en", 16'(ball_en), 16'd0);
        pulse_miss(1'b0, 1'b1);
        check_output("pause_miss", score, 16'h0000);
        pause = 1'b0;
        cycle(1);
        check_output("unpause_ball_en", 16'(ball_en), 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for the pong datapath. Decides when the ball/paddle update logic may run, when the ball is re-centred, and who serves. It owns both players' scores and drives the packed 16-bit score word to the seven-segment counter. Runs on the slow move clock domain, between the push-button/switch inputs and the ball-movement logic.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..9
SERVE_TICKS, 32, move ticks the ball is held centred before launch; at least 1
POINT_TICKS, 16, move ticks the ball is frozen at the miss position after a point; at least 1

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous active-high reset
tick  input  1  one-cycle enable per movement step
start  input  1  raw start button level; debounced upstream
miss_l  input  1  pulse: ball passed the left paddle, so P2 scores
miss_r  input  1  pulse: ball passed the right paddle, so P1 scores
ball_en  output  1  datapath may advance ball and paddles
ball_rst  output  1  datapath holds the ball at centre
serve_dir  output  1  launch direction: 0 = toward left, 1 = toward right
score_p1  output  4  P1 score, binary 0..WIN_SCORE
score_p2  output  4  P2 score, binary 0..WIN_SCORE
score  output  16  {4'h0, score_p1, 4'h0, score_p2} for the seven-segment display
game_over  output  1  high in OVER
winner  output  1  0 = P1 won, 1 = P2 won; valid while game_over is high
state_dbg  output  3  current state encoding

Behaviour:
- All outputs are registered; each changes on the clk edge after its cause.
- Start edge detection: start_q is registered each cycle; start_pulse = start & ~start_q. A held button never re-triggers.
- Reset, synchronous, overrides everything in any state:
  - state = IDLE, both scores = 0, delay counter = 0, start_q = 0.
  - ball_en = 0, ball_rst = 1, serve_dir = 0, game_over = 0, winner = 0.
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- IDLE: ball_en=0, ball_rst=1. On start_pulse: clear scores, load counter with SERVE_TICKS, go to SERVE.
- SERVE: ball_en=0, ball_rst=1.
  - On tick with counter==1, go to PLAY; otherwise on tick, decrement.
  - SERVE therefore lasts exactly SERVE_TICKS ticks.
- PLAY: ball_en=1, ball_rst=0.
  - miss_r only: P1 score +1, serve_dir <= 1.
  - miss_l only: P2 score +1, serve_dir <= 0.
  - miss_l and miss_r in the same cycle: no score change, serve_dir unchanged, load SERVE_TICKS, go to SERVE.
  - After a single miss, if the new score equals WIN_SCORE: go to OVER and set winner.
  - After a single miss otherwise: load POINT_TICKS, go to POINT.
- POINT: ball_en=0, ball_rst=0, so the ball stays frozen and visible.
  - Counts POINT_TICKS ticks the same way as SERVE, then loads SERVE_TICKS and goes to SERVE.
- OVER: game_over=1, ball_en=0, ball_rst=1. Scores hold.
  - On start_pulse: clear scores and game_over, load SERVE_TICKS, go to SERVE.
- miss_l and miss_r are ignored outside PLAY. tick is ignored in IDLE, PLAY and OVER.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- tick and start_pulse in the same IDLE cycle: only the transition happens; that tick does not decrement the counter.
- Illegal state encodings recover to IDLE on the next edge.
- The counter is wide enough for max(SERVE_TICKS, POINT_TICKS), computed with $clog2(max)+1.

Optional Feature:
PONG_PAUSE_EN
- Defined:
  - Adds input port pause (1 bit, level) and output port paused (1 bit, reset value 0).
  - While pause=1 in SERVE, PLAY or POINT: paused=1, ball_en forced to 0, ticks do not decrement the counter, and misses are ignored.
  - While paused, state, scores and serve_dir hold; ball_rst keeps its per-state value.
  - Pause is ignored in IDLE and OVER, where paused=0.
  - Deasserting pause resumes on the next cycle with the counter unchanged.
- Undefined: neither port exists, and behaviour is exactly as above.

Test Plan:
1. SERVE_TICKS=4, rst for 2 cycles, then a start pulse, then ticks every 5 cycles -> state_dbg 0→1; ball_rst=1 through 4 ticks; on the cycle after the 4th tick, state_dbg=2, ball_en=1, ball_rst=0. Holding start high gives no re-trigger.
2. In PLAY, pulse miss_r -> score_p1=1, score=16'h0100, serve_dir=1, state POINT with ball_en=0 for POINT_TICKS ticks, then SERVE with ball_rst=1.
3. WIN_SCORE=3, three miss_l points -> score=16'h0003, game_over=1, winner=1, state 4. A further miss_l leaves score unchanged. A start pulse then gives score=0, game_over=0, state SERVE.
4. In PLAY at 1-1, miss_l and miss_r in the same cycle -> scores stay 1-1, serve_dir unchanged, state SERVE.
5. At 2-1 in PLAY, assert rst for 1 cycle -> next edge: state 0, score=0, ball_en=0, ball_rst=1, game_over=0.
6. (PONG_PAUSE_EN) pause=1 in SERVE with counter=3 for 10 ticks -> counter stays 3 and paused=1. After release, exactly 3 more ticks reach PLAY. A miss during pause in PLAY changes no score.
